mem_responder: RTL and testbench

- Memory-side responder for the team's valid/ready memory bus; it is the slave end of the bus the BFM drives.
- Accepts one read or write request at a time from the initiator, inserts a configurable number of wait states, and performs the access on an internal single-port array.
- Signals completion with a one-cycle ready_o pulse. For reads, rdata_o is valid in the same cycle as that pulse.
- It is the DUT behind the memory testbench and the reference point for the monitor's transaction checks.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 26 ++
 rtl/mem_responder.sv | 98 +++++++++
 tb/tb_mem_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its storage array.
// Request fields are sized from the package default widths.
package mem_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_MEM_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                      wr;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_MEM_WIDTH-1:0]  wdata;
  } req_t;

  localparam logic [DEF_MEM_WIDTH-1:0] OOR_RDATA = '1;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous storage, DEPTH x MEM_WIDTH, no reset on contents.
// One-cycle registered read; rdata only updates on an enabled read.
// No backpressure: an enabled access always completes at the clock edge.
module mem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_WIDTH  = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk_i,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [MEM_WIDTH-1:0]  wdata,
  output logic [MEM_WIDTH-1:0]  rdata
);

  logic [MEM_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Slave end of the valid/ready memory bus: captures one request, waits, accesses the array.
// Latency: ready_o high in the cycle after edge N+1+WAIT_STATES for a request accepted at edge N.
// Backpressure: one request in flight; valid_i is ignored outside IDLE.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MEM_WIDTH   = DEF_MEM_WIDTH,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [MEM_WIDTH-1:0]  wdata_i,
  output logic                  ready_o,
  output logic [MEM_WIDTH-1:0]  rdata_o
);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  req_t           req_q, req_d;
  logic           access;
  logic           in_range;
  logic           rd_seen_q;
  logic           rd_oor_q;
  logic [MEM_WIDTH-1:0] arr_rdata;

  assign in_range = int'(req_q.addr) < DEPTH;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          req_d.wr    = wr_rd_en_i;
          req_d.addr  = addr_i;
          req_d.wdata = wdata_i;
          cnt_d       = 4'(WAIT_STATES);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      req_q     <= '0;
      ready_o   <= 1'b0;
      rd_seen_q <= 1'b0;
      rd_oor_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_o <= access;
      if (access && !req_q.wr) begin
        rd_seen_q <= 1'b1;
        rd_oor_q  <= !in_range;
      end
    end
  end

  // Out-of-range accesses never touch the array, so a dropped write leaves it intact.
  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_WIDTH  (MEM_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk_i (clk_i),
    .en    (access && in_range),
    .we    (req_q.wr),
    .addr  (req_q.addr),
    .wdata (req_q.wdata),
    .rdata (arr_rdata)
  );

  // Array rdata has no reset, so the flags select zero until the first read completes.
  assign rdata_o = !rd_seen_q ? '0 : (rd_oor_q ? OOR_RDATA : arr_rdata);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and 200 words,
// one with no wait states for back-to-back traffic.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        v2, wr2, rdy2;
  logic [7:0]  a2;
  logic [31:0] d2, rd2;
  logic        v0, wr0, rdy0;
  logic [7:0]  a0;
  logic [31:0] d0, rd0;

  int n_chk = 0;
  int n_err = 0;

  mem_responder #(.ADDR_WIDTH(8), .MEM_WIDTH(32), .DEPTH(200), .WAIT_STATES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(v2), .wr_rd_en_i(wr2), .addr_i(a2),
    .wdata_i(d2), .ready_o(rdy2), .rdata_o(rd2)
  );

  mem_responder #(.ADDR_WIDTH(8), .MEM_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(v0), .wr_rd_en_i(wr0), .addr_i(a0),
    .wdata_i(d0), .ready_o(rdy0), .rdata_o(rd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // sel=0 drives the two-wait-state instance, sel=1 the zero-wait-state one.
  // lat = posedges after the accepting edge until ready_o is seen high (-1 on timeout).
  task automatic txn(input bit sel, input logic wr, input logic [7:0] a, input logic [31:0] d,
                     input bit mut, output logic [31:0] rd, output int lat, output time acc_t);
    if (sel) begin v0 = 1'b1; wr0 = wr; a0 = a; d0 = d; end
    else     begin v2 = 1'b1; wr2 = wr; a2 = a; d2 = d; end
    @(posedge clk);
    acc_t = $time;
    lat   = -1;
    rd    = '0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (mut && k == 1 && !sel) begin a2 = 8'h30; d2 = 32'hBAD0BAD0; end
      if ((sel ? rdy0 : rdy2) === 1'b1) begin
        lat = k - 1;
        rd  = sel ? rd0 : rd2;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (sel) v0 = 1'b0; else v2 = 1'b0;
    if (lat >= 0) begin
      @(negedge clk);
      chk($sformatf("pulse_width sel%0d", sel), {31'b0, sel ? rdy0 : rdy2}, 32'd0);
    end
  endtask

  typedef struct {
    bit          sel;
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;   // rdata_o expected at the ready pulse (last read value for writes)
    int          exp_lat;
    bit          b2b;      // accepted exactly 3 cycles after the previous vector
  } vec_t;

  vec_t vt[17];

  initial begin
    logic [31:0] rd;
    int          lat;
    time         acc, prev_acc;

    vt[0]  = '{0, 1'b1, 8'h20, 32'h00000001, 32'h00000000, 3, 0};
    vt[1]  = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000, 3, 0};
    vt[2]  = '{0, 1'b0, 8'h10, 32'h00000000, 32'hDEADBEEF, 3, 0};
    vt[3]  = '{0, 1'b1, 8'hC8, 32'h12345678, 32'hDEADBEEF, 3, 0};
    vt[4]  = '{0, 1'b0, 8'hC8, 32'h00000000, 32'hFFFFFFFF, 3, 0};
    vt[5]  = '{0, 1'b1, 8'hC7, 32'hA5A5A5A5, 32'hFFFFFFFF, 3, 0};
    vt[6]  = '{0, 1'b0, 8'hC7, 32'h00000000, 32'hA5A5A5A5, 3, 0};
    vt[7]  = '{0, 1'b0, 8'h10, 32'h00000000, 32'hDEADBEEF, 3, 0};
    vt[8]  = '{0, 1'b1, 8'h30, 32'h0F0F0F0F, 32'hDEADBEEF, 3, 0};
    vt[9]  = '{1, 1'b1, 8'h00, 32'h00000011, 32'h00000000, 1, 0};
    vt[10] = '{1, 1'b0, 8'h00, 32'h00000000, 32'h00000011, 1, 1};
    vt[11] = '{1, 1'b1, 8'h01, 32'h00000022, 32'h00000011, 1, 1};
    vt[12] = '{1, 1'b0, 8'h01, 32'h00000000, 32'h00000022, 1, 1};
    vt[13] = '{1, 1'b1, 8'h02, 32'h00000033, 32'h00000022, 1, 1};
    vt[14] = '{1, 1'b0, 8'h02, 32'h00000000, 32'h00000033, 1, 1};
    vt[15] = '{1, 1'b1, 8'h03, 32'h00000044, 32'h00000033, 1, 1};
    vt[16] = '{1, 1'b0, 8'h03, 32'h00000000, 32'h00000044, 1, 1};

    rst_n = 1'b0;
    v0 = 1'b0; wr0 = 1'b0; a0 = '0; d0 = '0;
    v2 = 1'b1; wr2 = 1'b1; a2 = 8'h20; d2 = 32'h00000001;

    // Reset held with valid_i asserted: nothing may respond.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("reset_ready c%0d", c), {31'b0, rdy2}, 32'd0);
      chk($sformatf("reset_rdata c%0d", c), rd2, 32'd0);
    end
    rst_n = 1'b1;

    // Vector 0 starts mid-cycle right after release, so its latency proves first-edge acceptance.
    prev_acc = 0;
    for (int i = 0; i < 17; i++) begin
      txn(vt[i].sel, vt[i].wr, vt[i].a, vt[i].d, 1'b0, rd, lat, acc);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
      if (vt[i].b2b) chk($sformatf("vec%0d spacing", i), 32'(acc - prev_acc), 32'd30);
      prev_acc = acc;
    end

    // Reset during WAIT of a write: no pulse, write discarded.
    v2 = 1'b1; wr2 = 1'b1; a2 = 8'h20; d2 = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst ready", {31'b0, rdy2}, 32'd0);
    chk("midrst rdata", rd2, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst ready c%0d", c), {31'b0, rdy2}, 32'd0);
    end
    v2 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst ready", {31'b0, rdy2}, 32'd0);
    txn(1'b0, 1'b0, 8'h20, 32'h0, 1'b0, rd, lat, acc);
    chk("postrst read 0x20", rd, 32'h00000001);
    chk("postrst latency", 32'(lat), 32'd3);

    // Address/data changed during WAIT must not affect the captured write.
    txn(1'b0, 1'b1, 8'h2F, 32'h5555AAAA, 1'b1, rd, lat, acc);
    chk("mut write latency", 32'(lat), 32'd3);
    chk("mut write rdata held", rd, 32'h00000001);
    txn(1'b0, 1'b0, 8'h2F, 32'h0, 1'b0, rd, lat, acc);
    chk("mut read 0x2F", rd, 32'h5555AAAA);
    txn(1'b0, 1'b0, 8'h30, 32'h0, 1'b0, rd, lat, acc);
    chk("mut read 0x30", rd, 32'h0F0F0F0F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
